decode_unit: RTL and testbench
==============================

# decode_unit

Decode stage of the 5-stage pipelined MIPS core, directly downstream of the fetch unit. Owns the IF/ID pipeline register, the 32x32 register file, the main/ALU control decoder and early branch/jump resolution. Returns the next-PC select, branch target and jump target to fetch, and presents operands and control to the ID/EX register.

## Interface
- WIDTH, 32, datapath width; only 32 is supported.

- DU_CLK  in  1  clock, rising-edge.
- DU_RST  in  1  reset, asynchronous, active-low.
- DU_Instr  in  WIDTH  instruction from fetch.
- DU_PcPlus4  in  WIDTH  PC+4 from fetch.
- DU_StallD  in  1  hazard unit: hold the IF/ID register.
- DU_ForwardAD / DU_ForwardBD  in  1 each  select DU_ALUOutM instead of RD1/RD2 for the branch compare.
- DU_ALUOutM  in  WIDTH  memory-stage ALU result.
- DU_RegWriteW  in  1  writeback enable.
- DU_WriteRegW  in  5  writeback register.
- DU_ResultW  in  WIDTH  writeback data.
- DU_PcSrc  out  2  00 PC+4, 01 branch, 10 jump; 11 never driven.
- DU_PcBranch / DU_PcJump  out  WIDTH  branch / jump targets.
- DU_RD1 / DU_RD2  out  WIDTH  register-file read data (rs, rt).
- DU_Rs / DU_Rt / DU_Rd  out  5 each  InstrD[25:21] / [20:16] / [15:11].
- DU_SignImm  out  WIDTH  sign-extended InstrD[15:0].
- DU_RegWrite, DU_MemtoReg, DU_MemWrite, DU_ALUSrc, DU_RegDst, DU_Branch, DU_Jump  out  1 each  control.
- DU_ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.

## Operation
- IF/ID register (InstrD, PcPlus4D), priority: reset -> both 0; DU_StallD=1 -> hold; else DU_PcSrc!=00 -> flush, both 0; else load DU_Instr/DU_PcPlus4. No branch delay slot.
- Register file: 32 entries, all cleared on reset. Written at the rising edge when DU_RegWriteW=1 and DU_WriteRegW!=0. Register 0 always reads 0.
- Write-through bypass: if a read address equals DU_WriteRegW, DU_RegWriteW=1 and the address is nonzero, the read returns DU_ResultW in the same cycle.
- Decode of InstrD[31:26]:
  - R-type 000000, per funct:
    - 100000 add: RegWrite=1, RegDst=1, ALUControl=010.
    - 100010 sub: RegWrite=1, RegDst=1, ALUControl=110.
    - 100100 and: RegWrite=1, RegDst=1, ALUControl=000.
    - 100101 or: RegWrite=1, RegDst=1, ALUControl=001.
    - 101010 slt: RegWrite=1, RegDst=1, ALUControl=111.
    - Any other funct, including the all-zero bubble: all controls 0.
  - lw 100011: RegWrite=1, ALUSrc=1, MemtoReg=1, ALUControl=010.
  - sw 101011: MemWrite=1, ALUSrc=1, ALUControl=010.
  - beq 000100: Branch=1, ALUControl=110.
  - addi 001000: RegWrite=1, ALUSrc=1, ALUControl=010.
  - j 000010: Jump=1.
  - Any other opcode: all controls 0 (nop).
- Compare operands: A = ForwardAD ? ALUOutM : RD1; B likewise with ForwardBD and RD2.
- Next-PC select:
  - DU_PcSrc = 00 whenever DU_StallD=1.
  - Else 10 if Jump=1.
  - Else 01 if Branch=1 and A==B.
  - Else 00.
- DU_PcBranch = (SignImm<<2) + PcPlus4D, modulo 2^32.
- DU_PcJump = {PcPlus4D[31:28], InstrD[25:0], 2'b00}.

## Timing
- Fetch-to-decode latency is 1 cycle. All outputs are combinational from InstrD/PcPlus4D, the register file and the forwarding inputs.
- Reset values (InstrD=0): DU_PcSrc=00, all control 0, DU_RD1/DU_RD2=0, DU_SignImm=0, DU_PcBranch=0, DU_PcJump=0, Rs/Rt/Rd=0.
- A taken branch or jump in cycle N drives DU_PcSrc in cycle N. The edge ending cycle N redirects the PC and flushes IF/ID, so cycle N+1 decodes a bubble.
- Stall and taken branch in the same cycle: stall wins; DU_PcSrc=00 and IF/ID holds.
- Reset asserted mid-operation clears IF/ID and all registers immediately, without waiting for a clock edge.
- Writeback and read of the same register in the same cycle returns the new value (bypass).

## Test plan
- Reset: DU_RST low with random inputs -> all outputs 0 and DU_PcSrc=00. After release, read $5 -> 0.
- Writeback bypass: write $8=0xDEADBEEF while decoding add $9,$8,$0 -> DU_RD1=0xDEADBEEF the same cycle. Write to $0 -> $0 still reads 0.
- Taken beq:
  - Stimulus: PC+4=0x00000104, imm=0xFFFF, $1=$2=7.
  - Response: DU_PcSrc=01, DU_PcBranch=0x00000100. The next edge flushes IF/ID (InstrD=0).
- Jump: j target 0x0000040, PcPlus4D=0x40000008 -> DU_PcSrc=10, DU_PcJump=0x40000100.
- Stall: DU_StallD=1 for 3 cycles while a taken beq is in decode -> InstrD held, DU_PcSrc=00. On release -> DU_PcSrc=01.
- Forwarded compare: RD1=3, DU_ALUOutM=5, ForwardAD=1, RD2=5 -> branch taken. With ForwardAD=0 -> not taken.

Source files
------------

// File: rtl/decode_unit.sv
// Decode stage of the 5-stage MIPS pipeline: IF/ID register, register file,
// control decoder and early branch/jump resolution back to fetch.
module decode_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             DU_CLK,
  input  logic             DU_RST,
  input  logic [WIDTH-1:0] DU_Instr,
  input  logic [WIDTH-1:0] DU_PcPlus4,
  input  logic             DU_StallD,
  input  logic             DU_ForwardAD,
  input  logic             DU_ForwardBD,
  input  logic [WIDTH-1:0] DU_ALUOutM,
  input  logic             DU_RegWriteW,
  input  logic [4:0]       DU_WriteRegW,
  input  logic [WIDTH-1:0] DU_ResultW,
  output logic [1:0]       DU_PcSrc,
  output logic [WIDTH-1:0] DU_PcBranch,
  output logic [WIDTH-1:0] DU_PcJump,
  output logic [WIDTH-1:0] DU_RD1,
  output logic [WIDTH-1:0] DU_RD2,
  output logic [4:0]       DU_Rs,
  output logic [4:0]       DU_Rt,
  output logic [4:0]       DU_Rd,
  output logic [WIDTH-1:0] DU_SignImm,
  output logic             DU_RegWrite,
  output logic             DU_MemtoReg,
  output logic             DU_MemWrite,
  output logic             DU_ALUSrc,
  output logic             DU_RegDst,
  output logic             DU_Branch,
  output logic             DU_Jump,
  output logic [2:0]       DU_ALUControl
);

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned IMM_W    = 16;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [WIDTH-1:0] r_instr_d;
  logic [WIDTH-1:0] r_pc_plus4_d;
  logic [WIDTH-1:0] r_regs [NUM_REGS];

  logic [5:0]       w_opcode;
  logic [5:0]       w_funct;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;
  logic [WIDTH-1:0] w_cmp_a;
  logic [WIDTH-1:0] w_cmp_b;
  logic [WIDTH-1:0] w_sign_imm;
  logic [1:0]       w_pc_src;
  logic             w_reg_write;
  logic             w_mem_to_reg;
  logic             w_mem_write;
  logic             w_alu_src;
  logic             w_reg_dst;
  logic             w_branch;
  logic             w_jump;
  logic [2:0]       w_alu_ctl;

  assign w_opcode   = r_instr_d[31:26];
  assign w_funct    = r_instr_d[5:0];
  assign w_rs       = r_instr_d[25:21];
  assign w_rt       = r_instr_d[20:16];
  assign w_sign_imm = {{(WIDTH-IMM_W){r_instr_d[IMM_W-1]}}, r_instr_d[IMM_W-1:0]};

  // IF/ID register: stall holds, a redirect squashes the fetched instruction
  always_ff @(posedge DU_CLK or negedge DU_RST) begin
    if (!DU_RST) begin
      r_instr_d    <= '0;
      r_pc_plus4_d <= '0;
    end else if (!DU_StallD) begin
      if (w_pc_src != 2'b00) begin
        r_instr_d    <= '0;
        r_pc_plus4_d <= '0;
      end else begin
        r_instr_d    <= DU_Instr;
        r_pc_plus4_d <= DU_PcPlus4;
      end
    end
  end

  always_ff @(posedge DU_CLK or negedge DU_RST) begin
    if (!DU_RST) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (DU_RegWriteW && (DU_WriteRegW != 5'd0)) begin
      r_regs[DU_WriteRegW] <= DU_ResultW;
    end
  end

  // Reads see the in-flight writeback so WB and ID can share a cycle
  always_comb begin
    w_rd1 = r_regs[w_rs];
    w_rd2 = r_regs[w_rt];
    if (DU_RegWriteW && (DU_WriteRegW == w_rs)) w_rd1 = DU_ResultW;
    if (DU_RegWriteW && (DU_WriteRegW == w_rt)) w_rd2 = DU_ResultW;
    if (w_rs == 5'd0) w_rd1 = '0;
    if (w_rt == 5'd0) w_rd2 = '0;
  end

  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_mem_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_reg_dst    = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_alu_ctl    = 3'b000;
    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD:  w_alu_ctl = ALU_ADD;
          FN_SUB:  w_alu_ctl = ALU_SUB;
          FN_AND:  w_alu_ctl = ALU_AND;
          FN_OR:   w_alu_ctl = ALU_OR;
          FN_SLT:  w_alu_ctl = ALU_SLT;
          default: w_alu_ctl = 3'b000;
        endcase
        if (w_funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
          w_reg_write = 1'b1;
          w_reg_dst   = 1'b1;
        end
      end
      OP_LW: begin
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_mem_to_reg = 1'b1;
        w_alu_ctl    = ALU_ADD;
      end
      OP_SW: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_ctl   = ALU_ADD;
      end
      OP_BEQ: begin
        w_branch  = 1'b1;
        w_alu_ctl = ALU_SUB;
      end
      OP_ADDI: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_ctl   = ALU_ADD;
      end
      OP_J:    w_jump = 1'b1;
      default: w_jump = 1'b0;
    endcase
  end

  assign w_cmp_a = DU_ForwardAD ? DU_ALUOutM : w_rd1;
  assign w_cmp_b = DU_ForwardBD ? DU_ALUOutM : w_rd2;

  always_comb begin
    w_pc_src = 2'b00;
    if (!DU_StallD) begin
      if (w_jump)                              w_pc_src = 2'b10;
      else if (w_branch && (w_cmp_a == w_cmp_b)) w_pc_src = 2'b01;
    end
  end

  assign DU_PcSrc      = w_pc_src;
  assign DU_PcBranch   = (w_sign_imm << 2) + r_pc_plus4_d;
  assign DU_PcJump     = {r_pc_plus4_d[WIDTH-1:WIDTH-4], r_instr_d[25:0], 2'b00};
  assign DU_RD1        = w_rd1;
  assign DU_RD2        = w_rd2;
  assign DU_Rs         = w_rs;
  assign DU_Rt         = w_rt;
  assign DU_Rd         = r_instr_d[15:11];
  assign DU_SignImm    = w_sign_imm;
  assign DU_RegWrite   = w_reg_write;
  assign DU_MemtoReg   = w_mem_to_reg;
  assign DU_MemWrite   = w_mem_write;
  assign DU_ALUSrc     = w_alu_src;
  assign DU_RegDst     = w_reg_dst;
  assign DU_Branch     = w_branch;
  assign DU_Jump       = w_jump;
  assign DU_ALUControl = w_alu_ctl;

endmodule

// File: tb/tb_decode_unit.sv
// Bench for decode_unit: directed scenarios followed by random instruction
// streams, all checked against an instruction-level reference model.
module tb_decode_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr, pc4, alu_m, res_w;
  logic        stall, fwd_a, fwd_b, rw_w;
  logic [4:0]  wr_w;
  logic [1:0]  pc_src;
  logic [31:0] pc_branch, pc_jump, rd1, rd2, sign_imm;
  logic [4:0]  rs, rt, rd;
  logic        reg_write, mem_to_reg, mem_write, alu_src, reg_dst, branch, jump;
  logic [2:0]  alu_ctl;
  logic [9:0]  dut_ctrl;

  int n_checks;
  int n_errors;

  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic [31:0] m_rf [32];

  decode_unit dut (
    .DU_CLK(clk), .DU_RST(rst_n), .DU_Instr(instr), .DU_PcPlus4(pc4),
    .DU_StallD(stall), .DU_ForwardAD(fwd_a), .DU_ForwardBD(fwd_b),
    .DU_ALUOutM(alu_m), .DU_RegWriteW(rw_w), .DU_WriteRegW(wr_w),
    .DU_ResultW(res_w), .DU_PcSrc(pc_src), .DU_PcBranch(pc_branch),
    .DU_PcJump(pc_jump), .DU_RD1(rd1), .DU_RD2(rd2), .DU_Rs(rs), .DU_Rt(rt),
    .DU_Rd(rd), .DU_SignImm(sign_imm), .DU_RegWrite(reg_write),
    .DU_MemtoReg(mem_to_reg), .DU_MemWrite(mem_write), .DU_ALUSrc(alu_src),
    .DU_RegDst(reg_dst), .DU_Branch(branch), .DU_Jump(jump),
    .DU_ALUControl(alu_ctl)
  );

  assign dut_ctrl = {reg_write, mem_to_reg, mem_write, alu_src, reg_dst,
                     branch, jump, alu_ctl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected control word {RegWrite,MemtoReg,MemWrite,ALUSrc,RegDst,Branch,Jump,ALUCtl}
  function automatic logic [9:0] ref_ctrl(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: case (ins[5:0])
               6'h20:   return 10'b1_0_0_0_1_0_0_010;
               6'h22:   return 10'b1_0_0_0_1_0_0_110;
               6'h24:   return 10'b1_0_0_0_1_0_0_000;
               6'h25:   return 10'b1_0_0_0_1_0_0_001;
               6'h2A:   return 10'b1_0_0_0_1_0_0_111;
               default: return 10'b0;
             endcase
      6'h23:   return 10'b1_1_0_1_0_0_0_010;
      6'h2B:   return 10'b0_0_1_1_0_0_0_010;
      6'h04:   return 10'b0_0_0_0_0_1_0_110;
      6'h08:   return 10'b1_0_0_1_0_0_0_010;
      6'h02:   return 10'b0_0_0_0_0_0_1_000;
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (rw_w && wr_w == a) return res_w;
    return m_rf[a];
  endfunction

  function automatic logic [1:0] ref_pcsrc();
    logic [9:0]  c;
    logic [31:0] a, b;
    c = ref_ctrl(m_instr);
    a = fwd_a ? alu_m : ref_rd(m_instr[25:21]);
    b = fwd_b ? alu_m : ref_rd(m_instr[20:16]);
    if (stall) return 2'd0;
    if (c[3]) return 2'd2;
    if (c[4] && a == b) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] ref_imm();
    int v;
    v = int'($signed(m_instr[15:0]));
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_branch();
    int off;
    off = int'($signed(m_instr[15:0])) * 4;
    return m_pc4 + 32'(off);
  endfunction

  function automatic logic [31:0] ref_jump();
    return (m_pc4 & 32'hF000_0000) | (32'(m_instr[25:0]) * 32'd4);
  endfunction

  function automatic logic [31:0] mk_r(input logic [5:0] f, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic model_reset();
    m_instr = 32'd0;
    m_pc4   = 32'd0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  task automatic check_outputs();
    check_eq("pcsrc",    32'(pc_src), 32'(ref_pcsrc()));
    check_eq("pcbranch", pc_branch, ref_branch());
    check_eq("pcjump",   pc_jump, ref_jump());
    check_eq("rd1",      rd1, ref_rd(m_instr[25:21]));
    check_eq("rd2",      rd2, ref_rd(m_instr[20:16]));
    check_eq("fields",   32'({rs, rt, rd}), 32'(m_instr[25:11]));
    check_eq("signimm",  sign_imm, ref_imm());
    check_eq("ctrl",     32'(dut_ctrl), 32'(ref_ctrl(m_instr)));
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge
  task automatic cycle();
    logic [1:0] ps;
    @(negedge clk);
    check_outputs();
    ps = ref_pcsrc();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!stall) begin
        m_instr = (ps != 2'd0) ? 32'd0 : instr;
        m_pc4   = (ps != 2'd0) ? 32'd0 : pc4;
      end
      if (rw_w && wr_w != 5'd0) m_rf[wr_w] = res_w;
    end
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] v);
    instr = 32'd0; rw_w = 1'b1; wr_w = a; res_w = v;
    cycle();
    rw_w = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  s, t, d;
    logic [15:0] imm;
    s   = 5'($urandom_range(0, 7));
    t   = 5'($urandom_range(0, 7));
    d   = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    case ($urandom_range(0, 12))
      0:  return mk_r(6'h20, s, t, d);
      1:  return mk_r(6'h22, s, t, d);
      2:  return mk_r(6'h24, s, t, d);
      3:  return mk_r(6'h25, s, t, d);
      4:  return mk_r(6'h2A, s, t, d);
      5:  return mk_r(6'($urandom), s, t, d);
      6:  return mk_i(6'h23, s, t, imm);
      7:  return mk_i(6'h2B, s, t, imm);
      8:  return mk_i(6'h04, s, t, imm);
      9:  return mk_i(6'h08, s, t, imm);
      10: return {6'h02, 26'($urandom)};
      11: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_inputs();
    instr = rand_instr();
    pc4   = $urandom;
    stall = ($urandom_range(0, 4) == 0);
    fwd_a = ($urandom_range(0, 3) == 0);
    fwd_b = ($urandom_range(0, 3) == 0);
    alu_m = 32'($urandom_range(0, 3));
    rw_w  = $urandom_range(0, 1) == 1;
    wr_w  = 5'($urandom_range(0, 7));
    res_w = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst_n = 1'b0;
    rand_inputs();
    #1;
    check_outputs();
    check_eq("reset_pcsrc", 32'(pc_src), 32'd0);
    cycle();
    rand_inputs();
    cycle();
    rst_n = 1'b1;
    stall = 1'b0; fwd_a = 1'b0; fwd_b = 1'b0; rw_w = 1'b0; alu_m = 32'd0;
    pc4 = 32'h0000_0010;

    instr = mk_r(6'h20, 5'd5, 5'd0, 5'd9);
    cycle();
    check_eq("read_r5", rd1, 32'd0);

    instr = mk_r(6'h20, 5'd8, 5'd0, 5'd9);
    cycle();
    rw_w = 1'b1; wr_w = 5'd8; res_w = 32'hDEAD_BEEF;
    #1;
    check_eq("bypass_rd1", rd1, 32'hDEAD_BEEF);
    instr = mk_r(6'h20, 5'd0, 5'd0, 5'd9);
    cycle();
    rw_w = 1'b1; wr_w = 5'd0; res_w = 32'h1234_5678;
    #1;
    check_eq("r0_bypass", rd1, 32'd0);
    instr = mk_r(6'h20, 5'd8, 5'd0, 5'd9);
    cycle();
    rw_w = 1'b0;
    check_eq("r8_stored", rd1, 32'hDEAD_BEEF);
    instr = mk_r(6'h20, 5'd0, 5'd0, 5'd9);
    cycle();
    check_eq("r0_reads0", rd1, 32'd0);

    write_reg(5'd1, 32'd7);
    write_reg(5'd2, 32'd7);
    instr = mk_i(6'h04, 5'd1, 5'd2, 16'hFFFF); pc4 = 32'h0000_0104;
    cycle();
    check_eq("beq_pcsrc", 32'(pc_src), 32'd1);
    check_eq("beq_target", pc_branch, 32'h0000_0100);
    instr = mk_i(6'h08, 5'd3, 5'd4, 16'h0001);
    cycle();
    check_eq("beq_flush_ctrl", 32'(dut_ctrl), 32'd0);
    check_eq("beq_flush_rs", 32'(rs), 32'd0);

    instr = mk_i(6'h04, 5'd1, 5'd2, 16'hFFFF); pc4 = 32'h0000_0104;
    cycle();
    stall = 1'b1;
    instr = {6'h02, 26'h123};
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("stall_pcsrc", 32'(pc_src), 32'd0);
      check_eq("stall_hold_rs", 32'(rs), 32'd1);
      cycle();
    end
    stall = 1'b0;
    #1;
    check_eq("stall_release", 32'(pc_src), 32'd1);
    instr = 32'd0;
    cycle();

    instr = {6'h02, 26'h0000040}; pc4 = 32'h4000_0008;
    cycle();
    check_eq("jump_pcsrc", 32'(pc_src), 32'd2);
    check_eq("jump_target", pc_jump, 32'h4000_0100);
    instr = 32'd0;
    cycle();

    write_reg(5'd3, 32'd3);
    write_reg(5'd4, 32'd5);
    instr = mk_i(6'h04, 5'd3, 5'd4, 16'h0004); pc4 = 32'h0000_0200;
    cycle();
    fwd_a = 1'b1; alu_m = 32'd5;
    #1;
    check_eq("fwd_taken", 32'(pc_src), 32'd1);
    fwd_a = 1'b0;
    #1;
    check_eq("fwd_not_taken", 32'(pc_src), 32'd0);
    instr = 32'd0;
    cycle();

    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      cycle();
      if (i == 700) begin
        rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs();
        check_eq("async_rst_pcsrc", 32'(pc_src), 32'd0);
        cycle();
        rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
